// File: rtl/r_div_pkg.sv
// Shared state type and parameter helpers for the r_div_mc multicycle divider.
package r_div_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } r_div_state_e;

  function automatic int unsigned log2_radix(input int unsigned radix);
    return $clog2(radix);
  endfunction

  function automatic int unsigned n_iter(input int unsigned width, input int unsigned radix);
    return width / log2_radix(radix);
  endfunction

  function automatic bit radix_legal(input int unsigned radix);
    return (radix == 2) || (radix == 4) || (radix == 8) || (radix == 16);
  endfunction

  // Counter must stay at least one bit wide even when a single iteration suffices.
  function automatic int unsigned cnt_width(input int unsigned iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/r_div_radix_step.sv
// One divider iteration: LOG2R chained single-bit restoring cells, quotient bits MSB first.
module r_div_radix_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2R = 2
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [LOG2R-1:0] dvd_bits_i,
  output logic [WIDTH:0]   rem_o,
  output logic [LOG2R-1:0] quot_bits_o
);

  logic [WIDTH:0]   rem;
  logic [WIDTH+1:0] diff;

  always_comb begin
    rem         = rem_i;
    diff        = '0;
    quot_bits_o = '0;
    for (int i = LOG2R - 1; i >= 0; i--) begin
      // Sign bit of the widened difference tells whether the trial subtract underflowed.
      diff           = {rem, dvd_bits_i[i]} - {2'b00, divisor_i};
      quot_bits_o[i] = ~diff[WIDTH+1];
      rem            = diff[WIDTH+1] ? {rem[WIDTH-1:0], dvd_bits_i[i]} : diff[WIDTH:0];
    end
    rem_o = rem;
  end

endmodule

// File: rtl/r_div_mc.sv
// Multicycle restoring divider, log2(RADIX) quotient bits per clock, signed/unsigned.
// Optional R_DIV_EARLY_OUT_EN skips iteration when |divisor| > |dividend|.
module r_div_mc
  import r_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADIX = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             signed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned LOG2R  = log2_radix(RADIX);
  localparam int unsigned N_ITER = n_iter(WIDTH, RADIX);
  localparam int unsigned CNT_W  = cnt_width(N_ITER);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER - 1);

  if (!radix_legal(RADIX) || (WIDTH < LOG2R) || ((WIDTH % LOG2R) != 0)) begin : gen_param_check
    $error("r_div_mc: illegal WIDTH/RADIX combination");
  end

  r_div_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_raw_q;
  logic [WIDTH-1:0] dvs_raw_q;
  logic [WIDTH-1:0] dvd_shift_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH:0]   rem_q;
  logic             signed_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic             early_out;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_next;
  logic [LOG2R-1:0] quot_bits;

  // Operand signs only matter for signed operations; magnitude of MIN stays 2^(WIDTH-1).
  assign dvd_neg  = signed_q & dvd_raw_q[WIDTH-1];
  assign dvs_neg  = signed_q & dvs_raw_q[WIDTH-1];
  assign dvd_mag  = dvd_neg ? -dvd_raw_q : dvd_raw_q;
  assign dvs_mag  = dvs_neg ? -dvs_raw_q : dvs_raw_q;
  assign dvs_zero = (dvs_raw_q == '0);

`ifdef R_DIV_EARLY_OUT_EN
  assign early_out = ~dvs_zero & (dvs_mag > dvd_mag);
`else
  assign early_out = 1'b0;
`endif

  assign in_ready_o    = (state_q == StIdle);
  assign out_valid_o   = (state_q == StDone);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = div_by_zero_q;

  r_div_radix_step #(
    .WIDTH(WIDTH),
    .LOG2R(LOG2R)
  ) u_step (
    .rem_i      (rem_q),
    .divisor_i  (dvs_mag),
    .dvd_bits_i (dvd_shift_q[WIDTH-1 -: LOG2R]),
    .rem_o      (rem_next),
    .quot_bits_o(quot_bits)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid_i) state_d = StPrep;
      StPrep: state_d = (dvs_zero || early_out) ? StFix : StIter;
      StIter: if (cnt_q == '0) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush freezes all datapath registers, so a flushed result never reaches the outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      dvd_raw_q     <= '0;
      dvs_raw_q     <= '0;
      dvd_shift_q   <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      signed_q      <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else if (!flush_i) begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            dvd_raw_q <= dividend_i;
            dvs_raw_q <= divisor_i;
            signed_q  <= signed_i;
          end
        end
        StPrep: begin
          dvd_shift_q <= dvd_mag;
          quot_q      <= '0;
          cnt_q       <= CNT_LOAD;
          dbz_q       <= dvs_zero;
          rem_q       <= early_out ? {1'b0, dvd_mag} : '0;
        end
        StIter: begin
          dvd_shift_q <= dvd_shift_q << LOG2R;
          quot_q      <= (quot_q << LOG2R) | WIDTH'(quot_bits);
          rem_q       <= rem_next;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        StFix: begin
          if (dbz_q) begin
            quotient_q    <= '1;
            remainder_q   <= dvd_raw_q;
            div_by_zero_q <= 1'b1;
          end else begin
            quotient_q    <= (dvd_neg ^ dvs_neg) ? -quot_q : quot_q;
            remainder_q   <= dvd_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            div_by_zero_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
